// File: rtl/soc_system_clken_nco_if.sv
// Configuration bus for the clock-enable NCO bank.
// The master drives single-cycle channel writes. The slave reports a
// one-cycle error pulse when a write targets a channel that does not exist.
interface soc_system_clken_nco_if #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 32
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [ACC_W-1:0]  cfg_phase;
  logic              cfg_err;

  modport master (
    output cfg_wr,
    output cfg_ch,
    output cfg_inc,
    output cfg_phase,
    input  cfg_err
  );

  modport slave (
    input  cfg_wr,
    input  cfg_ch,
    input  cfg_inc,
    input  cfg_phase,
    output cfg_err
  );

endinterface

// File: rtl/soc_system_clken_nco.sv
// Bank of NUM_CH numerically-controlled clock-enable generators.
// Each channel adds its increment to a phase accumulator on every refclk edge.
// The carry out of that add becomes a one-cycle enable pulse.
// The accumulator MSB becomes a roughly 50% duty square wave.
// Increments and phases can be rewritten at runtime.
// A shared settle counter raises locked once no valid write has happened
// for LOCK_CYCLES edges.
module soc_system_clken_nco #(
  parameter int                      NUM_CH      = 2,
  parameter int                      ACC_W       = 32,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = {NUM_CH{1'b1, {(ACC_W-1){1'b0}}}},
  parameter int                      LOCK_CYCLES = 16
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 hold_i,
  soc_system_clken_nco_if.slave cfg,
  output logic [NUM_CH-1:0]    clken_o,
  output logic [NUM_CH-1:0]    outclk_o,
  output logic                 locked_o
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCNT_W-1:0] LOCK_MAX = LCNT_W'(LOCK_CYCLES);
  localparam logic [CH_W:0]     CH_LIMIT = (CH_W+1)'(NUM_CH);

  // Per-channel state, packed so a whole-bank reset load from INC_INIT is one assignment.
  logic [NUM_CH-1:0][ACC_W-1:0] acc_q;
  logic [NUM_CH-1:0][ACC_W-1:0] acc_d;
  logic [NUM_CH-1:0][ACC_W-1:0] inc_q;
  logic [NUM_CH-1:0][ACC_W-1:0] inc_d;
  logic [NUM_CH-1:0]            clken_q;
  logic [NUM_CH-1:0]            clken_d;
  logic [NUM_CH-1:0]            outclk_q;
  logic [NUM_CH-1:0]            outclk_d;

  // Shared settle tracking and config error pulse.
  logic [LCNT_W-1:0]            lock_cnt_q;
  logic [LCNT_W-1:0]            lock_cnt_d;
  logic                         locked_q;
  logic                         locked_d;
  logic                         cfg_err_q;
  logic                         cfg_err_d;

  // Write decode.
  logic                         ch_valid_s;
  logic                         wr_valid_s;
  logic [NUM_CH-1:0]            wr_sel_s;

  // Decode the config write: range-check the channel and one-hot select it.
  always_comb begin
    ch_valid_s = 1'b0;
    wr_valid_s = 1'b0;
    wr_sel_s   = '0;
    cfg_err_d  = 1'b0;
    if ({1'b0, cfg.cfg_ch} < CH_LIMIT) begin
      ch_valid_s = 1'b1;
    end else begin
      ch_valid_s = 1'b0;
    end
    if (cfg.cfg_wr) begin
      wr_valid_s = ch_valid_s;
      cfg_err_d  = ~ch_valid_s;
    end else begin
      wr_valid_s = 1'b0;
      cfg_err_d  = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_valid_s && (cfg.cfg_ch == CH_W'(i))) begin
        wr_sel_s[i] = 1'b1;
      end else begin
        wr_sel_s[i] = 1'b0;
      end
    end
  end

  // Per-channel next state. A write overrides accumulation, hold freezes the
  // phase, and otherwise the channel adds its increment and reports the carry.
  always_comb begin
    logic [ACC_W:0] sum_v;
    acc_d    = acc_q;
    inc_d    = inc_q;
    clken_d  = '0;
    outclk_d = outclk_q;
    sum_v    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_v = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      if (wr_sel_s[i]) begin
        // A newly written channel starts from the loaded phase and emits no pulse this edge.
        inc_d[i]    = cfg.cfg_inc;
        acc_d[i]    = cfg.cfg_phase;
        clken_d[i]  = 1'b0;
        outclk_d[i] = cfg.cfg_phase[ACC_W-1];
      end else if (!hold_i) begin
        // Overflow of the accumulator is the enable event, not an error.
        acc_d[i]    = sum_v[ACC_W-1:0];
        clken_d[i]  = sum_v[ACC_W];
        outclk_d[i] = sum_v[ACC_W-1];
      end else begin
        acc_d[i]    = acc_q[i];
        clken_d[i]  = 1'b0;
        outclk_d[i] = outclk_q[i];
      end
    end
  end

  // Settle counter. A valid write restarts it. It saturates at LOCK_CYCLES,
  // and locked is asserted on the edge where it arrives there.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = 1'b0;
    if (wr_valid_s) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q < LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + {{(LCNT_W-1){1'b0}}, 1'b1};
    end else begin
      lock_cnt_d = LOCK_MAX;
    end
    if (lock_cnt_d == LOCK_MAX) begin
      locked_d = 1'b1;
    end else begin
      locked_d = 1'b0;
    end
  end

  // State registers. Reset takes priority over config writes and hold.
  always_ff @(posedge refclk) begin
    if (rst) begin
      acc_q      <= '0;
      inc_q      <= INC_INIT;
      clken_q    <= '0;
      outclk_q   <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      clken_q    <= clken_d;
      outclk_q   <= outclk_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign clken_o     = clken_q;
  assign outclk_o    = outclk_q;
  assign locked_o    = locked_q;
  assign cfg.cfg_err = cfg_err_q;

endmodule
